decoder: RTL and testbench

Instruction-decode stage of the single-cycle MIPS-subset CPU.
- Holds the 32x32 general register file.
- Provides two combinational read ports addressed from the instruction.
- Produces the 32-bit immediate extension for the execute stage.
- Performs the clocked write-back of ALU, memory or JAL link data.

---
 rtl/decoder.sv | 149 ++++++++++++++
 tb/tb_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder: instruction-decode stage of the single-cycle MIPS-subset CPU.
//
// Holds the 32x32 general register file. It provides two combinational read
// ports (rs, rt) and the 32-bit immediate extension. It performs the clocked
// write-back of ALU, load or JAL link data.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset (identity preload reg[i]=i)
//   Instruction  current instruction: [31:26] op, [25:21] rs, [20:16] rt,
//                [15:11] rd, [15:0] imm
//   read_data    load data from data RAM / IO
//   ALU_result   ALU result for write-back
//   Jal          JAL: write opcplus4 into $31
//   RegWrite     register write enable
//   MemtoReg     1: write read_data, 0: write ALU_result
//   RegDst       1: destination rd, 0: destination rt
//   opcplus4     PC+4 link value
//   read_data_1  contents of rs
//   read_data_2  contents of rt
//   Sign_extend  extended immediate
//   register     live contents of every register (debug)
//
// Optional build macro: DECODER_WRITE_BYPASS_EN. When it is defined, the two
// read ports forward the write data of the current cycle (write-through).
// ---------------------------------------------------------------------------
module decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic [31:0] read_data,
  input  logic [31:0] ALU_result,
  input  logic        Jal,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        RegDst,
  input  logic [31:0] opcplus4,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  output logic [31:0] Sign_extend,
  output logic [31:0] register [0:31]
);

  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [4:0] LINK_REG = 5'd31;

  // $0 has no storage; only $1..$31 are real registers.
  logic [31:0] regs_q [1:31];

  logic [5:0]  opcode_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [15:0] imm_s;
  logic [4:0]  waddr_s;
  logic [31:0] wdata_s;
  logic        wen_s;

  assign opcode_s = Instruction[31:26];
  assign rs_s     = Instruction[25:21];
  assign rt_s     = Instruction[20:16];
  assign rd_s     = Instruction[15:11];
  assign imm_s    = Instruction[15:0];

  // Write address and data select; Jal overrides both RegDst and MemtoReg.
  always_comb begin
    waddr_s = rt_s;
    wdata_s = ALU_result;
    if (Jal) begin
      waddr_s = LINK_REG;
      wdata_s = opcplus4;
    end else begin
      if (RegDst) begin
        waddr_s = rd_s;
      end else begin
        waddr_s = rt_s;
      end
      if (MemtoReg) begin
        wdata_s = read_data;
      end else begin
        wdata_s = ALU_result;
      end
    end
  end

  // Writes to $0 are dropped here so the storage never needs an entry 0.
  assign wen_s = RegWrite && (waddr_s != 5'd0);

  // Register file update: reset preloads reg[i]=i and wins over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'(i);
      end
    end else if (wen_s) begin
      regs_q[waddr_s] <= wdata_s;
    end
  end

  // Immediate extension: the unsigned logical/compare immediates zero-extend.
  always_comb begin
    case (opcode_s)
      OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU: Sign_extend = {16'h0000, imm_s};
      default:                            Sign_extend = {{16{imm_s[15]}}, imm_s};
    endcase
  end

  // Read ports; $0 always reads zero.
  always_comb begin
    read_data_1 = 32'h0000_0000;
    read_data_2 = 32'h0000_0000;
    if (rs_s != 5'd0) begin
      read_data_1 = regs_q[rs_s];
    end else begin
      read_data_1 = 32'h0000_0000;
    end
    if (rt_s != 5'd0) begin
      read_data_2 = regs_q[rt_s];
    end else begin
      read_data_2 = 32'h0000_0000;
    end
`ifdef DECODER_WRITE_BYPASS_EN
    // Same-cycle write-through; wen_s already excludes $0.
    if (wen_s && !rst && (waddr_s == rs_s)) begin
      read_data_1 = wdata_s;
    end else begin
      read_data_1 = read_data_1;
    end
    if (wen_s && !rst && (waddr_s == rt_s)) begin
      read_data_2 = wdata_s;
    end else begin
      read_data_2 = read_data_2;
    end
`endif
  end

  // Debug view of committed state (never bypassed).
  always_comb begin
    register[0] = 32'h0000_0000;
    for (int i = 1; i < 32; i++) begin
      register[i] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder: self-checking bench for the decode-stage register file.
// Inputs are driven after the falling edge. Combinational outputs are
// compared 1 time unit later, and register state 1 time unit after the
// rising edge. All comparisons are against a plain array model.
// ---------------------------------------------------------------------------
module tb_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] Instruction;
  logic [31:0] read_data;
  logic [31:0] ALU_result;
  logic        Jal;
  logic        RegWrite;
  logic        MemtoReg;
  logic        RegDst;
  logic [31:0] opcplus4;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] Sign_extend;
  logic [31:0] register [0:31];

  logic [31:0] model [0:31];
  int          n_vec;
  int          n_err;

  decoder dut (
    .clk         (clk),
    .rst         (rst),
    .Instruction (Instruction),
    .read_data   (read_data),
    .ALU_result  (ALU_result),
    .Jal         (Jal),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .opcplus4    (opcplus4),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .Sign_extend (Sign_extend),
    .register    (register)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected immediate from the opcode class.
  function automatic logic [31:0] exp_ext(input logic [31:0] ins);
    int op;
    int imm;
    op  = int'(ins[31:26]);
    imm = int'(ins[15:0]);
    if (op == 12 || op == 13 || op == 14 || op == 11) return 32'(imm);
    if (imm >= 32768) return 32'(imm - 65536);
    return 32'(imm);
  endfunction

  function automatic int dest_reg();
    if (Jal) return 31;
    return RegDst ? int'(Instruction[15:11]) : int'(Instruction[20:16]);
  endfunction

  function automatic logic [31:0] dest_val();
    if (Jal) return opcplus4;
    return MemtoReg ? read_data : ALU_result;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rdat,
                       input logic jal, input logic we, input logic m2r, input logic rdst,
                       input logic [31:0] pc4, input logic r);
    @(negedge clk);
    Instruction = ins;
    ALU_result  = alu;
    read_data   = rdat;
    Jal         = jal;
    RegWrite    = we;
    MemtoReg    = m2r;
    RegDst      = rdst;
    opcplus4    = pc4;
    rst         = r;
    #1;
  endtask

  // Compare read ports and immediate against the model (pre-edge state).
  task automatic pre_check();
    logic [31:0] e1;
    logic [31:0] e2;
    int rs;
    int rt;
    rs = int'(Instruction[25:21]);
    rt = int'(Instruction[20:16]);
    e1 = model[rs];
    e2 = model[rt];
`ifdef DECODER_WRITE_BYPASS_EN
    if (RegWrite && !rst && dest_reg() != 0) begin
      if (dest_reg() == rs) e1 = dest_val();
      if (dest_reg() == rt) e2 = dest_val();
    end
`endif
    check("rd1", read_data_1, e1);
    check("rd2", read_data_2, e2);
    check("sext", Sign_extend, exp_ext(Instruction));
  endtask

  // Clock once, advance the model, and compare the whole register array.
  task automatic clock_and_check();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'(i);
    end else if (RegWrite && dest_reg() != 0) begin
      model[dest_reg()] = dest_val();
    end
    #1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("reg%0d", i), register[i], model[i]);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rdat,
                      input logic jal, input logic we, input logic m2r, input logic rdst,
                      input logic [31:0] pc4, input logic r);
    drive(ins, alu, rdat, jal, we, m2r, rdst, pc4, r);
    if (!r) pre_check();
    clock_and_check();
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    logic [5:0]  zops [0:3];
    n_vec = 0;
    n_err = 0;
    zops[0] = 6'b001100;
    zops[1] = 6'b001101;
    zops[2] = 6'b001110;
    zops[3] = 6'b001011;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset with a competing write.
    step(32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // add $7,$2,$3
    drive(32'h0043_3820, 32'd5, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    check("add_rs", read_data_1, 32'd2);
    check("add_rt", read_data_2, 32'd3);
    pre_check();
    clock_and_check();
    check("add_r7", register[7], 32'd5);

    // addi $3,$7,0x8037
    drive(32'h20E3_8037, 32'hFFFF_803C, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("addi_sext", Sign_extend, 32'hFFFF_8037);
    check("addi_rs", read_data_1, 32'd5);
    pre_check();
    clock_and_check();
    check("addi_r3", register[3], 32'hFFFF_803C);

    // andi $4,$2,0x8097
    drive(32'h3044_8097, 32'd2, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("andi_zext", Sign_extend, 32'h0000_8097);
    check("andi_rs", read_data_1, 32'd2);
    pre_check();
    clock_and_check();
    check("andi_r4", register[4], 32'd2);

    // lw $6,0x100($0)
    step(32'h8C06_0100, 32'h54, 32'h7B, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("lw_r6", register[6], 32'h7B);

    // jal
    step(32'h0C00_0006, 32'h44, 32'h55, 1'b1, 1'b1, 1'b1, 1'b0, 32'h18, 1'b0);
    check("jal_r31", register[31], 32'h18);
    check("jal_r0", register[0], 32'h0);

    // add $0,$1,$2 must not stick
    step(32'h0022_0020, 32'hDEAD, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    check("w0_r0", register[0], 32'h0);

    // Reset mid-sequence with RegWrite: identity preload
    step(32'h0022_3820, 32'hBEEF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 32; i++) check($sformatf("rst_r%0d", i), register[i], 32'(i));

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        op = zops[$urandom_range(0, 3)];
        ins[31:26] = op;
      end
      step(ins, $urandom, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
           ($urandom_range(0, 29) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
